// File: rtl/rasterbars_pkg.sv
// Shared types and helpers for the raster-bar renderer: 12-bit RGB colour,
// per-step colour increment, saturating channel add and the update FSM states.
package rasterbars_pkg;

    typedef logic [11:0] colr_t;

    typedef enum logic [1:0] {IDLE, INIT, CALC, DONE} upd_state_t;

    // Each intensity step adds one to every 4-bit channel.
    localparam colr_t COLR_STEP = 12'h111;

    // base + i*COLR_STEP, each 4-bit channel clamped at 0xF.
    function automatic colr_t colr_add_sat(input colr_t base, input logic [3:0] i);
        colr_t      r;
        logic [7:0] s;
        r = '0;
        for (int c = 0; c < 3; c++) begin
            s = 8'(base[4*c +: 4]) + 8'(i) * 8'(COLR_STEP[4*c +: 4]);
            r[4*c +: 4] = (s > 8'd15) ? 4'hF : s[3:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/rasterbar_grad.sv
// One bar's vertical colour gradient: triggered on its line, it ramps colour
// intensity up for STEPS steps then back down, COLR_LINES lines per step.
module rasterbar_grad
    import rasterbars_pkg::*;
#(
    parameter int STEPS      = 10,
    parameter int COLR_LINES = 3
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  line,
    input  logic  trig,
    input  colr_t base,
    output logic  drawing,
    output colr_t colr
);
    localparam int LW = (COLR_LINES > 1) ? $clog2(COLR_LINES) : 1;

    logic [4:0]    step;
    logic [LW-1:0] lcnt;
    logic [3:0]    inten;

    // Step/line counters; a trigger always restarts from the top of the bar.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step    <= '0;
            lcnt    <= '0;
            drawing <= 1'b0;
        end else if (trig) begin
            step    <= '0;
            lcnt    <= '0;
            drawing <= 1'b1;
        end else if (drawing && line) begin
            if (lcnt == LW'(COLR_LINES - 1)) begin
                lcnt <= '0;
                if (step == 5'(2*STEPS - 1)) drawing <= 1'b0;
                else                         step    <= step + 5'd1;
            end else begin
                lcnt <= lcnt + LW'(1);
            end
        end
    end

    // Intensity rises with step in the first half and mirrors in the second.
    always_comb begin
        inten = (step < 5'(STEPS)) ? step[3:0] : 4'(5'(2*STEPS - 1) - step);
        colr  = colr_add_sat(base, inten);
    end
endmodule

// File: rtl/sine_table.sv
// 256-entry signed sine source with a combinational read. Values come from a
// parabolic half-wave approximation: |y| = p*(128-p)/32 clamped to 127, where
// p is the phase within the half period; the upper half period is negated.
module sine_table (
    input  logic [7:0]        id,
    output logic signed [7:0] data
);
    logic [7:0]  p;
    logic [15:0] prod;
    logic [10:0] mag_w;
    logic [7:0]  mag;

    // Parabola magnitude, clamp, then sign by half period.
    always_comb begin
        p     = {1'b0, id[6:0]};
        prod  = 16'(p) * 16'(8'd128 - p);
        mag_w = 11'(prod >> 5);
        mag   = (mag_w > 11'd127) ? 8'd127 : mag_w[7:0];
        data  = id[7] ? -signed'(mag) : signed'(mag);
    end
endmodule

// File: rtl/render_rasterbars_n.sv
// Raster-bar renderer: once per frame the bar positions are recomputed from a
// scrolling sine index; each line, the lowest-index drawing bar supplies the
// colour. Define RASTERBARS_ZSORT_EN so rising bars are drawn in front.
module render_rasterbars_n
    import rasterbars_pkg::*;
#(
    parameter int CORDW      = 16,
    parameter int BARS       = 4,
    parameter int VCENTER    = 180,
    parameter int COLR_LINES = 3,
    parameter int STEPS      = 10,
    parameter int SPEED      = 1,
    parameter     SIN_FILE   = "",
    parameter int SIN_SHIFT  = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    line,
    input  logic signed [CORDW-1:0] sy,
    input  logic [12*BARS-1:0]      base_colr,
    output logic [11:0]             bar_colr,
    output logic                    bar_up,
    output logic [2:0]              bar_id,
    output logic                    upd_done
);
    localparam int KW = (BARS > 1) ? $clog2(BARS) : 1;

    upd_state_t state, state_nx;
    logic [7:0]               sin_id;
    logic [KW-1:0]            k;
    logic [7:0]               sin_addr;
    logic signed [7:0]        sin_data, sin_sh;
    logic signed [CORDW-1:0]  bar_new;
    logic signed [CORDW-1:0]  bar_y    [BARS];
    logic signed [CORDW-1:0]  bar_prev [BARS];
    logic [BARS-1:0]          drw, rising;
    colr_t                    gcolr [BARS];
    logic                     sel_any;
    logic [2:0]               sel;

    assign sin_addr = sin_id + 8'(32'(k) * (256 / BARS));
    assign sin_sh   = sin_data >>> SIN_SHIFT;
    assign bar_new  = CORDW'(VCENTER) + {{(CORDW-8){sin_sh[7]}}, sin_sh};

    sine_table u_sin (.id(sin_addr), .data(sin_data));

    // Update FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // Next state: start only accepted while idle.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start) state_nx = INIT;
            INIT: state_nx = CALC;
            CALC: if (k == KW'(BARS - 1)) state_nx = DONE;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Position datapath: one bar recomputed per CALC cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sin_id   <= '0;
            k        <= '0;
            upd_done <= 1'b0;
            for (int i = 0; i < BARS; i++) begin
                bar_y[i]    <= CORDW'(VCENTER);
                bar_prev[i] <= CORDW'(VCENTER);
            end
        end else begin
            upd_done <= (state == DONE);
            if (state == INIT) begin
                sin_id <= sin_id + 8'(SPEED);
                k      <= '0;
            end else if (state == CALC) begin
                bar_y[k]    <= bar_new;
                bar_prev[k] <= bar_y[k];
                k           <= k + KW'(1);
            end
        end
    end

    for (genvar g = 0; g < BARS; g++) begin : g_bar
        assign rising[g] = (bar_y[g] < bar_prev[g]);
        rasterbar_grad #(.STEPS(STEPS), .COLR_LINES(COLR_LINES)) u_grad (
            .clk     (clk),
            .rst_n   (rst_n),
            .line    (line),
            .trig    (line && (sy == bar_y[g])),
            .base    (base_colr[12*g +: 12]),
            .drawing (drw[g]),
            .colr    (gcolr[g])
        );
    end

    // Pick the visible bar: lowest-index drawing bar, rising bars first if sorted.
    always_comb begin
        sel_any = 1'b0;
        sel     = '0;
        for (int i = BARS - 1; i >= 0; i--) begin
            if (drw[i]) begin
                sel_any = 1'b1;
                sel     = 3'(i);
            end
        end
`ifdef RASTERBARS_ZSORT_EN
        for (int i = BARS - 1; i >= 0; i--) begin
            if (drw[i] && rising[i]) sel = 3'(i);
        end
`endif
    end

    // Registered pixel outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bar_colr <= '0;
            bar_up   <= 1'b0;
            bar_id   <= '0;
        end else begin
            bar_colr <= sel_any ? gcolr[sel[KW-1:0]]  : 12'h000;
            bar_up   <= sel_any ? rising[sel[KW-1:0]] : 1'b0;
            bar_id   <= sel;
        end
    end
endmodule

// File: tb/tb_render_rasterbars_n.sv
// Self-checking bench for render_rasterbars_n (default parameters).
// Build with +define+RASTERBARS_ZSORT_EN to check the depth-sorted variant.
module tb_render_rasterbars_n;
    localparam int CL = 3, ST = 10, VC = 180;

    logic               clk = 0, rst_n = 0, start = 0, line = 0;
    logic signed [15:0] sy = 0;
    logic [47:0]        base_colr = 0;
    logic [11:0]        bar_colr;
    logic               bar_up, upd_done;
    logic [2:0]         bar_id;
    int                 checks = 0, failures = 0;

    render_rasterbars_n dut (
        .clk(clk), .rst_n(rst_n), .start(start), .line(line), .sy(sy),
        .base_colr(base_colr), .bar_colr(bar_colr), .bar_up(bar_up),
        .bar_id(bar_id), .upd_done(upd_done)
    );

    always #5 clk = ~clk;

    typedef struct { logic [11:0] base; int idx; logic [11:0] exp; } vec_t;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Expected colour idx lines after the trigger line, from the gradient rules.
    function automatic int exp_colr(input int base, input int idx);
        int s, i, r, ch;
        if (idx < 0 || idx >= 2*ST*CL) return 0;
        s = idx / CL;
        i = (s < ST) ? s : 2*ST - 1 - s;
        r = 0;
        for (int c = 0; c < 3; c++) begin
            ch = ((base >> (4*c)) & 15) + i;
            if (ch > 15) ch = 15;
            r |= ch << (4*c);
        end
        return r;
    endfunction

    // Sine reference: parabolic half-wave, 127 peak, negative upper half.
    function automatic int sinv(input int a);
        int p, m;
        p = a % 128;
        m = p * (128 - p) / 32;
        if (m > 127) m = 127;
        return (a % 256 >= 128) ? -m : m;
    endfunction

    task automatic do_reset();
        rst_n = 0; start = 0; line = 0; sy = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        @(posedge clk); #1;
    endtask

    // One line pulse, then one more cycle so the registered output settles.
    task automatic do_line(input int y);
        sy = 16'(y); line = 1;
        @(posedge clk); #1 line = 0;
        @(posedge clk); #1;
    endtask

    task automatic run_lines(input int from, input int to);
        for (int y = from; y <= to; y++) do_line(y);
    endtask

    vec_t vecs [12];
    int   ups, b0, b2;

    initial begin
        vecs[0]  = '{12'h126, -1, 12'h000};
        vecs[1]  = '{12'h126,  0, 12'h126};
        vecs[2]  = '{12'h126,  2, 12'h126};
        vecs[3]  = '{12'h126,  3, 12'h237};
        vecs[4]  = '{12'h126, 27, 12'hABF};
        vecs[5]  = '{12'h126, 30, 12'hABF};
        vecs[6]  = '{12'h126, 33, 12'h9AE};
        vecs[7]  = '{12'h126, 57, 12'h126};
        vecs[8]  = '{12'h126, 59, 12'h126};
        vecs[9]  = '{12'h126, 60, 12'h000};
        vecs[10] = '{12'hEE0,  6, 12'hFF2};
        vecs[11] = '{12'hEE0,  0, 12'hEE0};

        // Reset state, no start.
        do_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_colr", bar_colr, 0);
        check("rst_done", upd_done, 0);
        check("rst_id", bar_id, 0);
        check("rst_up", bar_up, 0);
        for (int k = 0; k < 4; k++) check("rst_bar_y", int'(dut.bar_y[k]), VC);

        // One update: upd_done exactly 6 cycles after start; second start ignored.
        ups = 0;
        start = 1;
        @(posedge clk); #1 start = 0;
        for (int c = 1; c <= 10; c++) begin
            if (c == 2) start = 1;
            @(posedge clk); #1;
            start = 0;
            if (upd_done) ups++;
            if (c <= 8) check($sformatf("upd_done_c%0d", c), upd_done, (c == 6) ? 1 : 0);
        end
        check("upd_done_count", ups, 1);
        for (int k = 0; k < 4; k++)
            check($sformatf("bar_y%0d", k), int'(dut.bar_y[k]), VC + sinv(1 + 64*k));

        // Overlap: bar 2 (rising) triggers first, then bar 0 (falling).
        b0 = 12'h123; b2 = 12'h456;
        base_colr = {12'h789, 12'(b2), 12'hABC, 12'(b0)};
        run_lines(VC + sinv(129) - 2, VC + sinv(129));
        check("solo_id", bar_id, 2);
        check("solo_up", bar_up, 1);
        run_lines(VC + sinv(129) + 1, VC + sinv(1));
`ifdef RASTERBARS_ZSORT_EN
        check("ovl_id", bar_id, 2);
        check("ovl_up", bar_up, 1);
        check("ovl_colr", bar_colr, exp_colr(b2, sinv(1) - sinv(129)));
`else
        check("ovl_id", bar_id, 0);
        check("ovl_up", bar_up, 0);
        check("ovl_colr", bar_colr, exp_colr(b0, 0));
`endif

        // Reset in the middle of an update: no upd_done, positions back to centre.
        do_reset();
        start = 1;
        @(posedge clk); #1 start = 0;
        repeat (3) @(posedge clk);
        #1 rst_n = 0;
        #1 check("midupd_done", upd_done, 0);
        @(posedge clk); #1 rst_n = 1;
        ups = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (upd_done) ups++;
        end
        check("midupd_no_done", ups, 0);
        check("midupd_bar_y0", int'(dut.bar_y[0]), VC);

        // Table of gradient points, all bars sitting at the centre line.
        foreach (vecs[v]) begin
            do_reset();
            base_colr = {4{vecs[v].base}};
            run_lines(VC - 2, VC + vecs[v].idx);
            check($sformatf("vec%0d_colr", v), bar_colr, vecs[v].exp);
        end

        // Randomized base colours and line offsets against the reference model.
        for (int n = 0; n < 12; n++) begin
            int base, idx;
            base = int'($urandom_range(0, 12'hFFF));
            idx  = int'($urandom_range(0, 64));
            do_reset();
            base_colr = {4{12'(base)}};
            run_lines(VC, VC + idx);
            check($sformatf("rnd%0d_colr", n), bar_colr, exp_colr(base, idx));
            check($sformatf("rnd%0d_id", n), bar_id, 0);
        end

        // Retrigger while drawing restarts at step 0.
        do_reset();
        base_colr = {4{12'h300}};
        run_lines(VC, VC + 10);
        check("pre_retrig", bar_colr, exp_colr(12'h300, 10));
        do_line(VC);
        check("retrig_s0", bar_colr, 12'h300);
        run_lines(VC + 1, VC + 3);
        check("retrig_s1", bar_colr, 12'h411);

        // Reset mid-bar clears at once; only a new trigger redraws.
        run_lines(VC + 4, VC + 10);
        rst_n = 0;
        #1 check("midbar_rst", bar_colr, 0);
        @(posedge clk); #1 rst_n = 1;
        run_lines(VC + 11, VC + 20);
        check("post_rst_idle", bar_colr, 0);
        do_line(VC);
        check("post_rst_trig", bar_colr, 12'h300);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
